// File: rtl/hq_piso_stream.sv
// hq_piso_stream: parallel-in / serial-out streamer for a frame of NUM
// complex channel coefficients (Q8.8 real/imag, W bits each).
//
// A frame is captured from frame_in on load while idle, then presented one
// element per cycle on Hq_r/Hq_i with a valid/ready handshake. sof/eof mark
// the first/last element. done pulses for one cycle after the last transfer.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-low reset
//   load       capture request (honoured only in IDLE)
//   frame_in   NUM elements, element k at [2W*k +: 2W], {real, imag}
//   out_ready  downstream accepts the current element
//   Hq_r/Hq_i  current element (0 when out_valid=0)
//   out_valid  Hq_r/Hq_i valid
//   sof/eof    current element is element 0 / element NUM-1
//   busy       frame captured and not yet fully transferred (SHIFT or DONE)
//   done       one-cycle pulse after the last element is accepted
//
// Build option: define HQ_PISO_CONJ_EN to output the saturated negation of
// the imaginary part (conjugate); otherwise imag passes through unmodified.

module hq_piso_stream #(
    parameter int unsigned NUM = 8,
    parameter int unsigned W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [NUM*2*W-1:0]   frame_in,
    input  logic                 out_ready,
    output logic [W-1:0]         Hq_r,
    output logic [W-1:0]         Hq_i,
    output logic                 out_valid,
    output logic                 sof,
    output logic                 eof,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int unsigned EW    = 2 * W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [EW-1:0]     elem_q [NUM];
    logic [EW-1:0]     elem_d [NUM];
    logic [W-1:0]      hq_r_q, hq_r_d;
    logic [W-1:0]      hq_i_q, hq_i_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Element presented on the next cycle and whether one is presented at all
    logic              present;
    logic [EW-1:0]     pres_elem;

    // Imaginary output mapping: pass-through or saturated negation
    function automatic logic [W-1:0] imag_out(input logic [W-1:0] im);
`ifdef HQ_PISO_CONJ_EN
        // The most negative value has no positive counterpart; clamp to max
        if (im == {1'b1, {(W-1){1'b0}}}) begin
            return {1'b0, {(W-1){1'b1}}};
        end
        return W'(~im + W'(1));
`else
        return im;
`endif
    endfunction

    // Next-state, storage and registered-output computation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        elem_d    = elem_q;
        done_d    = 1'b0;
        present   = 1'b0;
        pres_elem = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    for (int k = 0; k < int'(NUM); k++) begin
                        elem_d[k] = frame_in[EW*k +: EW];
                    end
                    idx_d     = '0;
                    state_d   = ST_SHIFT;
                    present   = 1'b1;
                    pres_elem = frame_in[EW-1:0];
                end
            end
            ST_SHIFT: begin
                present   = 1'b1;
                pres_elem = elem_q[idx_q];
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        present = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        pres_elem = elem_q[idx_q + IDX_W'(1)];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        valid_d = present;
        sof_d   = present && (idx_d == '0);
        eof_d   = present && (idx_d == LAST_IDX);
        busy_d  = (state_d != ST_IDLE);
        hq_r_d  = present ? pres_elem[EW-1:W] : '0;
        hq_i_d  = present ? imag_out(pres_elem[W-1:0]) : '0;
    end

    // State, storage and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            for (int k = 0; k < int'(NUM); k++) begin
                elem_q[k] <= '0;
            end
            hq_r_q  <= '0;
            hq_i_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            elem_q  <= elem_d;
            hq_r_q  <= hq_r_d;
            hq_i_q  <= hq_i_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Hq_r      = hq_r_q;
    assign Hq_i      = hq_i_q;
    assign out_valid = valid_q;
    assign sof       = sof_q;
    assign eof       = eof_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hq_piso_stream.sv
// Testbench for hq_piso_stream: directed frames plus random load/ready/reset
// traffic, checked every cycle against a queue-based reference model.

module tb_hq_piso_stream;

    localparam int unsigned NUM = 8;
    localparam int unsigned W   = 16;

    logic                 clk;
    logic                 rst;
    logic                 load;
    logic [NUM*2*W-1:0]   frame_in;
    logic                 out_ready;
    logic [W-1:0]         Hq_r;
    logic [W-1:0]         Hq_i;
    logic                 out_valid;
    logic                 sof;
    logic                 eof;
    logic                 busy;
    logic                 done;

    hq_piso_stream #(.NUM(NUM), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .frame_in  (frame_in),
        .out_ready (out_ready),
        .Hq_r      (Hq_r),
        .Hq_i      (Hq_i),
        .out_valid (out_valid),
        .sof       (sof),
        .eof       (eof),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] i;
        int           pos;
    } elem_t;

    // Reference: elements still owed downstream, plus a pending done slot
    elem_t q[$];
    bit    m_done;
    int    n_cmp;
    int    n_err;
    int    cyc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Expected imaginary output from the stored value
    function automatic logic [W-1:0] exp_imag(input logic [W-1:0] im);
`ifdef HQ_PISO_CONJ_EN
        int v;
        v = -int'($signed(im));
        if (v > 32767) v = 32767;
        return W'(v);
`else
        return im;
`endif
    endfunction

    task automatic check_outputs();
        bit          v;
        logic [W-1:0] er, ei;
        v  = (q.size() > 0);
        er = v ? q[0].r : '0;
        ei = v ? exp_imag(q[0].i) : '0;
        check_eq("out_valid", 32'(out_valid), 32'(v));
        check_eq("hq_r",      32'(Hq_r),      32'(er));
        check_eq("hq_i",      32'(Hq_i),      32'(ei));
        check_eq("sof",       32'(sof),       32'(v && q[0].pos == 0));
        check_eq("eof",       32'(eof),       32'(v && q[0].pos == int'(NUM) - 1));
        check_eq("busy",      32'(busy),      32'(v || m_done));
        check_eq("done",      32'(done),      32'(m_done));
    endtask

    task automatic model_step();
        elem_t e;
        if (!rst) begin
            q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (q.size() == 0) begin
            if (load) begin
                for (int k = 0; k < int'(NUM); k++) begin
                    e.r   = frame_in[2*W*k + W +: W];
                    e.i   = frame_in[2*W*k +: W];
                    e.pos = k;
                    q.push_back(e);
                end
            end
        end else if (out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) m_done = 1'b1;
        end
    endtask

    // One clock: drive, check at negedge, advance model at posedge
    task automatic run_cycle(input logic ld, input logic rdy, input logic rs);
        load      = ld;
        out_ready = rdy;
        rst       = rs;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic set_spec_frame();
        for (int k = 0; k < int'(NUM); k++) begin
            frame_in[2*W*k + W +: W] = W'(k * 256);
            frame_in[2*W*k +: W]     = W'(16 + k);
        end
    endtask

    task automatic set_random_frame();
        for (int k = 0; k < int'(NUM * 2 * W / 32); k++) begin
            frame_in[32*k +: 32] = $urandom;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        cyc    = 0;
        m_done = 1'b0;
        load      = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        frame_in  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        q.delete();

        // Reset state, then a frame streamed with ready held high
        run_cycle(1'b0, 1'b1, 1'b0);
        set_spec_frame();
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 12; c++) run_cycle(1'b0, 1'b1, 1'b1);

        // Ready toggling 1,0,1,0
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) run_cycle(1'b0, logic'(c % 2 == 0), 1'b1);

        // Load pulsed while element 3 is presented, with a different frame
        set_spec_frame();
        run_cycle(1'b1, 1'b1, 1'b1);
        set_random_frame();
        for (int c = 0; c < 12; c++) run_cycle(logic'(c == 3), 1'b1, 1'b1);

        // Reset while element 5 is presented, then restart
        set_spec_frame();
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) run_cycle(1'b0, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b1, 1'b1);
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 11; c++) run_cycle(1'b0, 1'b1, 1'b1);

        // Imaginary edge values (0x0100, 0x8000, 0x0000, 0x7FFF, 0xFFFF)
        set_random_frame();
        frame_in[0 +: W]       = 16'h0100;
        frame_in[2*W +: W]     = 16'h8000;
        frame_in[4*W +: W]     = 16'h0000;
        frame_in[6*W +: W]     = 16'h7FFF;
        frame_in[8*W +: W]     = 16'hFFFF;
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) run_cycle(1'b0, 1'b1, 1'b1);

        // Load held high: back-to-back frames
        for (int c = 0; c < 40; c++) begin
            set_random_frame();
            run_cycle(1'b1, 1'b1, 1'b1);
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            set_random_frame();
            run_cycle(logic'($urandom_range(3) == 0),
                      logic'($urandom_range(2) != 0),
                      logic'($urandom_range(63) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hq_piso_stream.md
HQ_PISO_STREAM -- requirements
Module: hq_piso_stream

Interface
- REQ-001 Parameter NUM, default 8: number of complex channel coefficients per frame (2..16).
- REQ-002 Parameter W, default 16: width of each real/imag component, Q8.8 two's complement.
- REQ-003 clk  input  1: single clock; all state changes on its rising edge.
- REQ-004 rst  input  1: synchronous, active-low reset (rst=0 at a rising edge resets).
- REQ-005 load  input  1: request to capture a new frame from frame_in.
- REQ-006 frame_in  input  NUM*2*W: element k at bits [2W*k +: 2W], real in upper W bits, imag in lower W bits.
- REQ-007 out_ready  input  1: downstream accepts the current element.
- REQ-008 Hq_r  output  W: real part of the current element.
- REQ-009 Hq_i  output  W: imaginary part of the current element.
- REQ-010 out_valid  output  1: Hq_r/Hq_i hold a valid element.
- REQ-011 sof  output  1: current element is element 0; serves as the start strobe for the downstream accumulator.
- REQ-012 eof  output  1: current element is element NUM-1.
- REQ-013 busy  output  1: a frame is captured and not yet fully transferred.
- REQ-014 done  output  1: one-cycle pulse after the last element is accepted.

Function
- REQ-015 The block SHALL implement states IDLE, SHIFT and DONE, plus an index counter of width clog2(NUM).
- REQ-016 In IDLE, load=1 SHALL capture frame_in, clear the index to 0, and enter SHIFT on the next edge.
- REQ-017 In SHIFT, out_valid SHALL be 1 and Hq_r/Hq_i SHALL present element [index], registered (not combinational from frame_in).
- REQ-018 A transfer SHALL occur only on a cycle with out_valid=1 and out_ready=1; on a transfer the index SHALL increment by 1.
- REQ-019 With out_ready=0, outputs SHALL hold stable and the index SHALL not change (no drop, no duplicate).
- REQ-020 sof SHALL equal out_valid AND (index==0); eof SHALL equal out_valid AND (index==NUM-1).
- REQ-021 A transfer while eof=1 SHALL enter DONE; the index SHALL wrap to 0 and not run past NUM-1.
- REQ-022 DONE SHALL last exactly one cycle with done=1 and out_valid=0, then return to IDLE.
- REQ-023 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
- REQ-024 load asserted in SHIFT or DONE SHALL be ignored; the captured frame SHALL be unaffected.
- REQ-025 load held high through DONE SHALL start a new frame on the first IDLE cycle, giving a minimum gap of 2 cycles between frames.
- REQ-026 With out_ready held at 1, the first element SHALL appear 1 cycle after load, and NUM elements SHALL transfer on NUM consecutive cycles.
- REQ-027 Hq_r/Hq_i SHALL be 0 whenever out_valid=0.

Reset
- REQ-028 At reset, the state SHALL be IDLE and the index 0; Hq_r, Hq_i, out_valid, sof, eof, busy and done SHALL all be 0.
- REQ-029 A reset asserted mid-frame SHALL abort the frame immediately with no done pulse; the next frame requires a new load.
- REQ-030 The frame storage SHALL be cleared to 0 at reset.

Configuration
- REQ-031 With macro HQ_PISO_CONJ_EN defined, Hq_i SHALL output the saturated negation of the stored imaginary part (0x8000 maps to 0x7FFF); Hq_r is unchanged.
- REQ-032 With HQ_PISO_CONJ_EN undefined, Hq_i SHALL output the stored imaginary part unmodified, and no negation logic SHALL be present.

Verification
- REQ-033 Reset, then load with element k = {r=k*0x0100, i=0x0010+k}, out_ready=1 -> 8 consecutive valid cycles; sof on element 0, eof on element 7; done 1 cycle later; busy low after that.
- REQ-034 Same frame with out_ready toggling 1,0,1,0 -> each element appears once, held during ready=0; done after the 8th transfer.
- REQ-035 load pulsed on the cycle of element 3 -> ignored; elements 4..7 unchanged; only one done pulse.
- REQ-036 rst=0 at element 5 -> all outputs 0 the next cycle, no done; a new load restarts at element 0.
- REQ-037 HQ_PISO_CONJ_EN defined, imag values 0x0100, 0x8000, 0x0000 -> Hq_i = 0xFF00, 0x7FFF, 0x0000.
- REQ-038 load held high continuously -> frames back-to-back with a 2-cycle gap (DONE, IDLE); sof appears on every frame.
